switches: RTL and testbench

//  Memory-mapped input peripheral for the RISC-V core: CPU-side read path for board switches.
//  - Synchronises and debounces WIDTH switch inputs.
//  - Latches rising edges in sticky flags.
//  - Returns state or flags on a 32-bit read bus.
//  - Inbound counterpart of the LED output register; sits on the same peripheral bus decode.

---
 rtl/switches.sv | 126 ++++++++++++
 tb/tb_switches.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switches.sv
// Board-switch read peripheral: 2-FF synchroniser, per-bit debounce, sticky rising-edge flags, 32-bit read bus.
// Optional interrupt mask and irq_o are enabled by defining SW_IRQ_EN.
module switches #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] sw_i,
    input  logic [1:0]       addr_i,
    input  logic             re_i,
    input  logic             we_i,
    input  logic [31:0]      dato_i,
    output logic [31:0]      dato_o,
    output logic             irq_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [31:0]      mask_rd;
    logic [31:0]      rd_data;
    logic             unused_dato;

    // Upper write-data bits carry no register state when WIDTH < 32.
    assign unused_dato = ^dato_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise   = deb_d & ~deb_q;
    assign clr    = (we_i && addr_i == 2'd1) ? dato_i[WIDTH-1:0] : '0;
    // A new rising edge beats a same-cycle clear.
    assign edge_d = (edge_q & ~clr) | rise;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            deb_q  <= '0;
            edge_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q  <= deb_d;
            edge_q <= edge_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SW_IRQ_EN
    logic [WIDTH-1:0] mask_q;
    logic             irq_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (we_i && addr_i == 2'd2) begin
                mask_q <= dato_i[WIDTH-1:0];
            end
            irq_q <= |(edge_q & mask_q);
        end
    end

    assign irq_o   = irq_q;
    assign mask_rd = 32'(mask_q);
`else
    assign irq_o   = 1'b0;
    assign mask_rd = '0;
`endif

    always_comb begin
        rd_data = '0;
        case (addr_i)
            2'd0:    rd_data = 32'(deb_q);
            2'd1:    rd_data = 32'(edge_q);
            2'd2:    rd_data = mask_rd;
            default: rd_data = '0;
        endcase
    end

    // Read data reflects pre-write register contents and holds between reads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dato_o <= '0;
        end else if (re_i) begin
            dato_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_switches.sv
// Bench for switches (WIDTH=16, DEBOUNCE_CYCLES=4): directed scenarios then random traffic,
// every cycle compared against a run-length reference model.
module tb_switches;

    localparam int W = 16;
    localparam int D = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [W-1:0]  sw_i;
    logic [1:0]    addr_i;
    logic          re_i;
    logic          we_i;
    logic [31:0]   dato_i;
    logic [31:0]   dato_o;
    logic          irq_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_s1   = '0;
    logic [W-1:0] m_s2   = '0;
    logic [W-1:0] m_deb  = '0;
    logic [W-1:0] m_edge = '0;
    logic [W-1:0] m_mask = '0;
    logic [31:0]  m_dato = '0;
    logic         m_irq  = 1'b0;
    int           run [W];

    switches #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .sw_i   (sw_i),
        .addr_i (addr_i),
        .re_i   (re_i),
        .we_i   (we_i),
        .dato_i (dato_i),
        .dato_o (dato_o),
        .irq_o  (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a pin value is adopted once the synchronised pin has disagreed
    // with the accepted value for D consecutive cycles.
    task automatic model_update();
        logic [W-1:0] nd;
        logic [W-1:0] rs;
        logic [W-1:0] cl;
        logic [31:0]  rd;
        if (reset_i) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_edge = '0; m_mask = '0;
            m_dato = '0; m_irq = 1'b0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            nd = m_deb;
            rs = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] !== m_deb[i]) begin
                    run[i]++;
                    if (run[i] >= D) begin
                        nd[i] = m_s2[i];
                        rs[i] = m_s2[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            cl = (we_i && addr_i == 2'd1) ? dato_i[W-1:0] : '0;
            case (addr_i)
                2'd0:    rd = {16'h0, m_deb};
                2'd1:    rd = {16'h0, m_edge};
`ifdef SW_IRQ_EN
                2'd2:    rd = {16'h0, m_mask};
`else
                2'd2:    rd = 32'h0;
`endif
                default: rd = 32'h0;
            endcase
            if (re_i) m_dato = rd;
`ifdef SW_IRQ_EN
            m_irq = |(m_edge & m_mask);
            if (we_i && addr_i == 2'd2) m_mask = dato_i[W-1:0];
`else
            m_irq = 1'b0;
`endif
            m_edge = (m_edge & ~cl) | rs;
            m_deb  = nd;
            m_s2   = m_s1;
            m_s1   = sw_i;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        #1;
        chk("dato_o", dato_o, m_dato);
        chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd_reg(input logic [1:0] a);
        addr_i = a; re_i = 1'b1;
        tick();
        re_i = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        addr_i = a; dato_i = d; we_i = 1'b1;
        tick();
        we_i = 1'b0; dato_i = '0;
    endtask

    task automatic settle(input logic [W-1:0] v);
        sw_i = v;
        ticks(8);
        wr_reg(2'd1, 32'h0000FFFF);
    endtask

    initial begin
        int idx;
        int r;
        reset_i = 1'b1; sw_i = 16'hFFFF; addr_i = 2'd0;
        re_i = 1'b0; we_i = 1'b0; dato_i = '0;

        // Switches held high through reset re-qualify after release.
        ticks(2);
        chk("reset_dato", dato_o, 32'h0);
        chk("reset_irq", {31'h0, irq_o}, 32'h0);
        reset_i = 1'b0;
        addr_i = 2'd0; re_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t1_state", dato_o, (k >= 7) ? 32'h0000FFFF : 32'h0);
        end
        re_i = 1'b0;
        rd_reg(2'd1);
        chk("t1_edge", dato_o, 32'h0000FFFF);

        // Bit 3 toggling every 2 cycles never qualifies.
        settle('0);
        addr_i = 2'd0; re_i = 1'b1;
        sw_i[3] = 1'b1; tick(); chk("t2_tog", {31'h0, dato_o[3]}, 32'h0);
        tick(); chk("t2_tog", {31'h0, dato_o[3]}, 32'h0);
        sw_i[3] = 1'b0; tick(); chk("t2_tog", {31'h0, dato_o[3]}, 32'h0);
        tick(); chk("t2_tog", {31'h0, dato_o[3]}, 32'h0);
        sw_i[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t2_state3", {31'h0, dato_o[3]}, (k >= 7) ? 32'h1 : 32'h0);
        end
        re_i = 1'b0;

        // W1C of one flag.
        settle('0);
        sw_i = 16'h0009;
        ticks(8);
        rd_reg(2'd1);
        chk("t3_edge_pre", dato_o, 32'h00000009);
        wr_reg(2'd1, 32'h00000001);
        rd_reg(2'd1);
        chk("t3_edge_post", dato_o, 32'h00000008);

        // Clear lands on the same edge as the bit-5 rise.
        settle('0);
        sw_i[5] = 1'b1;
        ticks(5);
        wr_reg(2'd1, 32'h00000020);
        rd_reg(2'd1);
        chk("t4_set_wins", dato_o, 32'h00000020);

        // Addr 3 reads zero, STATE ignores writes.
        rd_reg(2'd3);
        chk("t6_addr3", dato_o, 32'h0);
        wr_reg(2'd0, 32'hFFFFFFFF);
        wr_reg(2'd3, 32'hFFFFFFFF);
        rd_reg(2'd0);
        chk("t6_state", dato_o, 32'h00000020);
        rd_reg(2'd2);
`ifndef SW_IRQ_EN
        chk("t6_mask_none", dato_o, 32'h0);
`endif

        // Masked interrupt.
        settle('0);
        wr_reg(2'd2, 32'h00000004);
        sw_i[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
`ifdef SW_IRQ_EN
            chk("t5_irq_rise", {31'h0, irq_o}, (k >= 7) ? 32'h1 : 32'h0);
`else
            chk("t5_irq_tied", {31'h0, irq_o}, 32'h0);
`endif
        end
        wr_reg(2'd1, 32'h00000004);
`ifdef SW_IRQ_EN
        chk("t5_irq_hold", {31'h0, irq_o}, 32'h1);
`endif
        tick();
        chk("t5_irq_clr", {31'h0, irq_o}, 32'h0);
        sw_i[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t5_unmasked", {31'h0, irq_o}, 32'h0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 63);
            if (r == 0) begin
                sw_i = 16'($urandom_range(0, 65535));
            end else if (r < 8) begin
                idx = $urandom_range(0, W - 1);
                sw_i[idx] = ~sw_i[idx];
            end
            reset_i = ($urandom_range(0, 199) == 0);
            re_i    = 1'($urandom_range(0, 1));
            we_i    = ($urandom_range(0, 3) == 0);
            addr_i  = 2'($urandom_range(0, 3));
            dato_i  = $urandom;
            tick();
        end
        reset_i = 1'b0; re_i = 1'b0; we_i = 1'b0;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
